axi_ar_arbiter: RTL and testbench
=================================

AXI_AR_ARBITER -- requirements
Module: axi_ar_arbiter

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset, with ports as listed below.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 ARID_M0, ARID_M1  input  `AXI_ID_BITS (4)  master read IDs.
REQ-005 ARADDR_M0, ARADDR_M1  input  `AXI_ADDR_BITS (32)  read addresses.
REQ-006 ARLEN_M0/M1, ARSIZE_M0/M1, ARBURST_M0/M1  input  4/3/2  burst attributes.
REQ-007 ARVALID_M0, ARVALID_M1  input  1  master address valid.
REQ-008 ARREADY_M0, ARREADY_M1  output  1  master address ready.
REQ-009 ARID_S  output  `AXI_IDS_BITS (8)  {master tag, master ID}; tag 4'h0 = M0, 4'h1 = M1.
REQ-010 ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S  output  32/4/3/2  granted master payload, fed to the address decoder.
REQ-011 ARVALID_S  output  1  shared address valid.
REQ-012 ARREADY_S  input  1  ready returned by the decoder.
REQ-013 RID_S  input  8;  RVALID_S, RREADY_S, RLAST_S  input  1  read-data channel monitor.
REQ-014 gnt_o  output  2  one-hot current grant {M1,M0}; busy_o  output  1  transaction outstanding.

Function
REQ-015 FSM states: IDLE, ADDR, DATA; one outstanding read transaction at a time.
REQ-016 IDLE: if any ARVALID_Mx is high at edge N, register grant and enter ADDR; ARVALID_S is high from cycle N+1.
REQ-017 IDLE with both requesting: grant per REQ-030/031; with neither: stay IDLE, gnt_o = 0.
REQ-018 ADDR: ARVALID_S = granted ARVALID_Mx; payload and ARID_S muxed combinationally from the granted master only.
REQ-019 ADDR: ARREADY_Mx = ARREADY_S AND state==ADDR AND gnt_o[x]; the non-granted master's ARREADY SHALL be 0.
REQ-020 ADDR handshake (ARVALID_S & ARREADY_S) -> DATA; update last-grant register.
REQ-021 ADDR with granted ARVALID deasserting before handshake -> IDLE; last-grant unchanged; no transaction counted.
REQ-022 DATA: ARVALID_S = 0, all ARREADY_Mx = 0; exit to IDLE on RVALID_S & RREADY_S & RLAST_S with RID_S[7:4] equal to the granted tag.
REQ-023 DATA: beats with non-matching RID_S tag or RLAST_S = 0 SHALL be ignored.
REQ-024 busy_o = 1 in ADDR and DATA; gnt_o is held constant from entry to ADDR until return to IDLE.
REQ-025 The minimum turnaround is a new grant in the cycle after the RLAST handshake, i.e. one IDLE cycle between transactions.

Reset
REQ-026 rst high at an edge SHALL force IDLE from any state, including mid-ADDR or mid-DATA, regardless of channel activity.
REQ-027 Reset values: ARVALID_S 0, ARREADY_M0/M1 0, gnt_o 2'b00, busy_o 0, payload outputs 0.
REQ-028 Reset SHALL set last-grant to M1 so that M0 wins the first contested arbitration.
REQ-029 Signals sampled in the reset cycle SHALL NOT create a grant.

Configuration
REQ-030 With macro AXI_ARB_RR_EN defined: round-robin; a contested IDLE grant goes to the master not granted last.
REQ-031 Without AXI_ARB_RR_EN: fixed priority; M0 always wins a contested IDLE grant; last-grant is unused.

Verification
REQ-032 After reset, M0 requests ARADDR 0x0000_0100, ARLEN 3 -> ARVALID_S 1 cycle later, ARID_S 8'h0X, gnt_o 2'b01, DATA after ARREADY_S, IDLE after the 4th beat with RLAST and RID_S 8'h0X.
REQ-033 Both request continuously, 3 single-beat reads with RR_EN -> grant order M0, M1, M0; without RR_EN -> M0, M0, M0.
REQ-034 M1 granted, ARREADY_S held 0 for 5 cycles -> ARREADY_M0 stays 0, gnt_o stays 2'b10, ARADDR_S stays the M1 address.
REQ-035 In DATA, RLAST beat with RID_S tag 4'h0 while M1 is granted -> stays DATA; matching beat -> IDLE next cycle.
REQ-036 rst asserted mid-DATA -> next cycle IDLE, busy_o 0, gnt_o 0, ARVALID_S 0; the following contested request is granted to M0.

Source files
------------

// File: rtl/axi_ar_arbiter.sv
// rtl/axi_ar_arbiter.sv - two-master AXI read-address arbiter, one outstanding read (AXI_ARB_RR_EN selects round-robin)
`ifndef AXI_ID_BITS
`define AXI_ID_BITS 4
`endif
`ifndef AXI_IDS_BITS
`define AXI_IDS_BITS 8
`endif
`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif

module axi_ar_arbiter (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [`AXI_ID_BITS-1:0]    ARID_M0,
   input  logic [`AXI_ADDR_BITS-1:0]  ARADDR_M0,
   input  logic [3:0]                 ARLEN_M0,
   input  logic [2:0]                 ARSIZE_M0,
   input  logic [1:0]                 ARBURST_M0,
   input  logic                       ARVALID_M0,
   output logic                       ARREADY_M0,
   input  logic [`AXI_ID_BITS-1:0]    ARID_M1,
   input  logic [`AXI_ADDR_BITS-1:0]  ARADDR_M1,
   input  logic [3:0]                 ARLEN_M1,
   input  logic [2:0]                 ARSIZE_M1,
   input  logic [1:0]                 ARBURST_M1,
   input  logic                       ARVALID_M1,
   output logic                       ARREADY_M1,
   output logic [`AXI_IDS_BITS-1:0]   ARID_S,
   output logic [`AXI_ADDR_BITS-1:0]  ARADDR_S,
   output logic [3:0]                 ARLEN_S,
   output logic [2:0]                 ARSIZE_S,
   output logic [1:0]                 ARBURST_S,
   output logic                       ARVALID_S,
   input  logic                       ARREADY_S,
   input  logic [`AXI_IDS_BITS-1:0]   RID_S,
   input  logic                       RVALID_S,
   input  logic                       RREADY_S,
   input  logic                       RLAST_S,
   output logic [1:0]                 gnt_o,
   output logic                       busy_o
);

   typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

   state_t     state, state_nxt;
   logic [1:0] gnt_q;
   logic [1:0] pick;
   logic       sel_valid;
   logic       ar_hs;
   logic       r_done;
   logic [3:0] gnt_tag;
   logic       unused_rid;

   // Only the master tag in the upper nibble identifies the returning burst.
   assign unused_rid = ^RID_S[3:0];

`ifdef AXI_ARB_RR_EN
   logic last_m1;

   always_ff @(posedge clk) begin
      if (rst)
         last_m1 <= 1'b1;
      else if (ar_hs)
         last_m1 <= gnt_q[1];
   end
`endif

   always_comb begin
      pick = 2'b00;
      if (ARVALID_M0 && ARVALID_M1) begin
`ifdef AXI_ARB_RR_EN
         pick = last_m1 ? 2'b01 : 2'b10;
`else
         pick = 2'b01;
`endif
      end else if (ARVALID_M0) begin
         pick = 2'b01;
      end else if (ARVALID_M1) begin
         pick = 2'b10;
      end
   end

   assign sel_valid = (gnt_q[0] & ARVALID_M0) | (gnt_q[1] & ARVALID_M1);
   assign ar_hs     = (state == ADDR) && sel_valid && ARREADY_S;
   assign gnt_tag   = gnt_q[1] ? 4'h1 : 4'h0;
   assign r_done    = RVALID_S && RREADY_S && RLAST_S &&
                      (RID_S[`AXI_IDS_BITS-1:`AXI_IDS_BITS-4] == gnt_tag);

   // State and grant register; grant lives exactly as long as the transaction.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         gnt_q <= 2'b00;
      end else begin
         state <= state_nxt;
         if (state == IDLE && state_nxt == ADDR)
            gnt_q <= pick;
         else if (state_nxt == IDLE)
            gnt_q <= 2'b00;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (pick != 2'b00) state_nxt = ADDR;
         ADDR: begin
            if (ar_hs)
               state_nxt = DATA;
            else if (!sel_valid)
               state_nxt = IDLE;
         end
         DATA: if (r_done) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      gnt_o      = gnt_q;
      busy_o     = (state != IDLE);
      ARVALID_S  = (state == ADDR) && sel_valid;
      ARREADY_M0 = (state == ADDR) && gnt_q[0] && ARREADY_S;
      ARREADY_M1 = (state == ADDR) && gnt_q[1] && ARREADY_S;
      ARID_S     = '0;
      ARADDR_S   = '0;
      ARLEN_S    = '0;
      ARSIZE_S   = '0;
      ARBURST_S  = '0;
      if (gnt_q[0]) begin
         ARID_S    = {4'h0, ARID_M0};
         ARADDR_S  = ARADDR_M0;
         ARLEN_S   = ARLEN_M0;
         ARSIZE_S  = ARSIZE_M0;
         ARBURST_S = ARBURST_M0;
      end else if (gnt_q[1]) begin
         ARID_S    = {4'h1, ARID_M1};
         ARADDR_S  = ARADDR_M1;
         ARLEN_S   = ARLEN_M1;
         ARSIZE_S  = ARSIZE_M1;
         ARBURST_S = ARBURST_M1;
      end
   end

endmodule

// File: tb/tb_axi_ar_arbiter.sv
// tb/tb_axi_ar_arbiter.sv - directed self-checking bench for axi_ar_arbiter
`timescale 1ns/1ps

module tb_axi_ar_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  ARID_M0, ARID_M1;
   logic [31:0] ARADDR_M0, ARADDR_M1;
   logic [3:0]  ARLEN_M0, ARLEN_M1;
   logic [2:0]  ARSIZE_M0, ARSIZE_M1;
   logic [1:0]  ARBURST_M0, ARBURST_M1;
   logic        ARVALID_M0, ARVALID_M1;
   logic        ARREADY_M0, ARREADY_M1;
   logic [7:0]  ARID_S;
   logic [31:0] ARADDR_S;
   logic [3:0]  ARLEN_S;
   logic [2:0]  ARSIZE_S;
   logic [1:0]  ARBURST_S;
   logic        ARVALID_S, ARREADY_S;
   logic [7:0]  RID_S;
   logic        RVALID_S, RREADY_S, RLAST_S;
   logic [1:0]  gnt_o;
   logic        busy_o;

   int tests_run = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   axi_ar_arbiter dut (
      .clk(clk), .rst(rst),
      .ARID_M0(ARID_M0), .ARADDR_M0(ARADDR_M0), .ARLEN_M0(ARLEN_M0),
      .ARSIZE_M0(ARSIZE_M0), .ARBURST_M0(ARBURST_M0),
      .ARVALID_M0(ARVALID_M0), .ARREADY_M0(ARREADY_M0),
      .ARID_M1(ARID_M1), .ARADDR_M1(ARADDR_M1), .ARLEN_M1(ARLEN_M1),
      .ARSIZE_M1(ARSIZE_M1), .ARBURST_M1(ARBURST_M1),
      .ARVALID_M1(ARVALID_M1), .ARREADY_M1(ARREADY_M1),
      .ARID_S(ARID_S), .ARADDR_S(ARADDR_S), .ARLEN_S(ARLEN_S),
      .ARSIZE_S(ARSIZE_S), .ARBURST_S(ARBURST_S),
      .ARVALID_S(ARVALID_S), .ARREADY_S(ARREADY_S),
      .RID_S(RID_S), .RVALID_S(RVALID_S), .RREADY_S(RREADY_S), .RLAST_S(RLAST_S),
      .gnt_o(gnt_o), .busy_o(busy_o)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic rbeat(input logic [7:0] id, input logic last, input logic rdy);
      RID_S = id; RVALID_S = 1'b1; RREADY_S = rdy; RLAST_S = last;
      tick();
      RVALID_S = 1'b0; RREADY_S = 1'b0; RLAST_S = 1'b0;
   endtask

   // One contested single-beat read from IDLE; returns the grant it received.
   task automatic single_read(output logic [1:0] g);
      tick();
      g = gnt_o;
      ARREADY_S = 1'b1;
      tick();
      ARREADY_S = 1'b0;
      rbeat(g[1] ? 8'h1A : 8'h05, 1'b1, 1'b1);
   endtask

   logic [1:0] g;
   logic [1:0] exp_seq [3];

   initial begin
      rst = 1'b1;
      ARID_M0 = 4'h5; ARADDR_M0 = 32'h0000_0100; ARLEN_M0 = 4'd3;
      ARSIZE_M0 = 3'd2; ARBURST_M0 = 2'd1;
      ARID_M1 = 4'hA; ARADDR_M1 = 32'h0000_0200; ARLEN_M1 = 4'd0;
      ARSIZE_M1 = 3'd3; ARBURST_M1 = 2'd2;
      ARVALID_M0 = 1'b1; ARVALID_M1 = 1'b1; ARREADY_S = 1'b0;
      RID_S = 8'h00; RVALID_S = 1'b0; RREADY_S = 1'b0; RLAST_S = 1'b0;

      // Reset with requests active must not grant.
      tick(); tick();
      check("rst_arvalid_s", ARVALID_S, 0);
      check("rst_gnt", gnt_o, 0);
      check("rst_busy", busy_o, 0);
      check("rst_arready", {ARREADY_M1, ARREADY_M0}, 0);
      check("rst_araddr_s", ARADDR_S, 0);
      check("rst_arid_s", ARID_S, 0);
      rst = 1'b0; ARVALID_M0 = 1'b0; ARVALID_M1 = 1'b0;
      tick();
      check("idle_no_req_gnt", gnt_o, 0);

      // M0 burst of 4 beats.
      ARVALID_M0 = 1'b1;
      tick();
      check("m0_arvalid_s", ARVALID_S, 1);
      check("m0_gnt", gnt_o, 2'b01);
      check("m0_arid_s", ARID_S, 8'h05);
      check("m0_araddr_s", ARADDR_S, 32'h100);
      check("m0_arlen_s", ARLEN_S, 3);
      check("m0_arready_wait", ARREADY_M0, 0);
      ARREADY_S = 1'b1; #1;
      check("m0_arready", {ARREADY_M1, ARREADY_M0}, 2'b01);
      tick();
      ARVALID_M0 = 1'b0; ARREADY_S = 1'b0; #1;
      check("m0_data_arvalid_s", ARVALID_S, 0);
      check("m0_data_busy", busy_o, 1);
      for (int i = 0; i < 3; i++) rbeat(8'h05, 1'b0, 1'b1);
      check("m0_beat3_busy", busy_o, 1);
      rbeat(8'h05, 1'b1, 1'b1);
      check("m0_done_busy", busy_o, 0);
      check("m0_done_gnt", gnt_o, 0);

      // Continuous contention, three single-beat reads.
`ifdef AXI_ARB_RR_EN
      exp_seq[0] = 2'b01; exp_seq[1] = 2'b10; exp_seq[2] = 2'b01;
`else
      exp_seq[0] = 2'b01; exp_seq[1] = 2'b01; exp_seq[2] = 2'b01;
`endif
      do_reset();
      ARVALID_M0 = 1'b1; ARVALID_M1 = 1'b1;
      for (int i = 0; i < 3; i++) begin
         single_read(g);
         check($sformatf("contest_gnt%0d", i), g, exp_seq[i]);
         check($sformatf("contest_idle%0d", i), busy_o, 0);
      end

      // M1 granted and stalled; M0 joins late and must stay blocked.
      do_reset();
      ARVALID_M0 = 1'b0; ARVALID_M1 = 1'b1;
      tick();
      ARVALID_M0 = 1'b1;
      for (int i = 0; i < 5; i++) begin
         check("stall_gnt", gnt_o, 2'b10);
         check("stall_arready_m0", ARREADY_M0, 0);
         check("stall_araddr_s", ARADDR_S, 32'h200);
         tick();
      end
      check("stall_arid_s", ARID_S, 8'h1A);
      ARREADY_S = 1'b1; #1;
      check("stall_arready", {ARREADY_M1, ARREADY_M0}, 2'b10);
      tick();
      ARREADY_S = 1'b0; ARVALID_M0 = 1'b0; ARVALID_M1 = 1'b0;

      // Wrong tag and unhandshaken beats are ignored in DATA.
      rbeat(8'h0A, 1'b1, 1'b1);
      check("wrong_tag_busy", busy_o, 1);
      rbeat(8'h1A, 1'b1, 1'b0);
      check("no_rready_busy", busy_o, 1);
      rbeat(8'h1A, 1'b1, 1'b1);
      check("match_tag_busy", busy_o, 0);

      // Abandoned address phase returns to IDLE without moving last-grant.
      ARVALID_M0 = 1'b1;
      tick();
      check("abort_arvalid_s", ARVALID_S, 1);
      ARVALID_M0 = 1'b0; #1;
      check("abort_arvalid_low", ARVALID_S, 0);
      tick();
      check("abort_busy", busy_o, 0);
      ARVALID_M0 = 1'b1; ARVALID_M1 = 1'b1;
      tick();
      check("after_abort_gnt", gnt_o, 2'b01);

      // Reset in the middle of DATA.
      ARREADY_S = 1'b1;
      tick();
      ARREADY_S = 1'b0;
      check("pre_rst_data", busy_o, 1);
      rst = 1'b1; RVALID_S = 1'b1; RREADY_S = 1'b1;
      tick();
      rst = 1'b0; RVALID_S = 1'b0; RREADY_S = 1'b0;
      check("mid_rst_busy", busy_o, 0);
      check("mid_rst_gnt", gnt_o, 0);
      check("mid_rst_arvalid_s", ARVALID_S, 0);
      tick();
      check("post_rst_gnt", gnt_o, 2'b01);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
